ras: RTL
========

Name: ras

Overview:
- Return address stack for the branch-prediction front end.
- Consumes the return-site hit produced by the return-PC lookup in F1 and supplies the predicted return target for that fetch.
- Speculative copy updated from F1 calls/returns; committed copy updated from EXE-resolved calls/returns.
- On a pipeline flush the speculative copy is restored from the committed copy.

Parameters:
- DEPTH, 16, number of stack entries; power of two, at least 2.
- PTR_BITS, $clog2(DEPTH), localparam: width of the stack pointer.
- CNT_BITS, $clog2(DEPTH)+1, localparam: width of the occupancy counter.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- spec_push  in  1  F1 predicted call (jal/jalr)
- spec_push_addr  in  32  return address of that call (call pc+8)
- spec_pop  in  1  F1 return hit (rpct hit qualified by F1 valid)
- commit_push  in  1  EXE-resolved call
- commit_push_addr  in  32  return address of the resolved call
- commit_pop  in  1  EXE-resolved jr ra
- flush  in  1  EXE redirect; restore speculative state from committed state
- top  out  32  predicted return target (speculative top of stack)
- top_valid  out  1  speculative stack non-empty

Behaviour:
- Storage:
  - Two arrays of DEPTH x 32 (spec, commit).
  - Each array has a circular pointer ptr (next free slot, PTR_BITS) and an occupancy count (CNT_BITS).
  - All arrays, pointers and counts reset asynchronously to 0.
- Outputs:
  - top = spec[spec_ptr-1] (mod DEPTH); top_valid = (spec_cnt != 0).
  - Both are combinational from registered state: zero-latency read, reflecting updates up to the previous edge.
  - Reset values: top = 0, top_valid = 0.
- Update rules (apply identically to each copy with its own push/pop/addr):
  - Push only: entry[ptr] <= addr; ptr <= ptr+1 (wraps DEPTH-1 -> 0); cnt <= min(cnt+1, DEPTH).
  - Full push (cnt == DEPTH): overwrites the oldest entry; cnt stays DEPTH; no error signalled.
  - Pop only, cnt > 0: ptr <= ptr-1 (wraps 0 -> DEPTH-1); cnt <= cnt-1; entry data untouched.
  - Pop only, cnt == 0: no state change (underflow ignored).
  - Push and pop together, cnt > 0: entry[ptr-1] <= addr; ptr and cnt unchanged (return followed by call replaces top).
  - Push and pop together, cnt == 0: behaves as push only.
- Flush:
  - Priority over spec_push/spec_pop; spec inputs are ignored in the flush cycle.
  - Next spec array/ptr/cnt = next commit array/ptr/cnt. This includes any commit_push/commit_pop in the same cycle (commit update is forwarded into the restore).
  - After a flush, top/top_valid equal committed top/non-empty from the next cycle.
- Commit copy is never affected by spec inputs or by flush.
- Reset asserted mid-operation clears both copies immediately (async). First update occurs on the first clk edge after resetn deasserts.

Test Plan:
- Reset, then 3 spec_push of 0x8000_0010/0x8000_0020/0x8000_0030 -> top = 0x8000_0030, top_valid = 1; then 3 spec_pop -> top follows 0x8000_0020, 0x8000_0010, then top_valid = 0.
- Empty stack, spec_pop for 2 cycles -> top_valid stays 0, ptr/cnt unchanged; a following spec_push 0x1234_5678 -> top = 0x1234_5678, top_valid = 1.
- DEPTH+2 (18) pushes of values 1..18, then 16 pops -> tops read 18 down to 3; after the 16th pop top_valid = 0 (values 1 and 2 lost to overwrite).
- Stack holds {0xA0, 0xB0}; spec_push 0xC0 with spec_pop in the same cycle -> top = 0xC0, count still 2; the next pop exposes 0xA0.
- Spec pushes 0x100, 0x200 with commit push of 0x100 only, then flush -> next cycle top = 0x100, top_valid = 1; spec_push asserted during the flush is ignored.
- Flush coincident with commit_push 0x300 on an empty commit stack -> next cycle top = 0x300, top_valid = 1; resetn pulsed low mid-sequence -> top_valid = 0 and top = 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ras.sv
// ras: return address stack with speculative copy restored from committed copy on flush
module ras #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spec_push,
  input  logic [31:0] spec_push_addr,
  input  logic        spec_pop,
  input  logic        commit_push,
  input  logic [31:0] commit_push_addr,
  input  logic        commit_pop,
  input  logic        flush,
  output logic [31:0] top,
  output logic        top_valid
);
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH) + 1;

  logic [31:0]         spec_q [DEPTH];
  logic [31:0]         spec_d [DEPTH];
  logic [31:0]         com_q  [DEPTH];
  logic [31:0]         com_d  [DEPTH];
  logic [PTR_BITS-1:0] sptr_q, sptr_d, cptr_q, cptr_d;
  logic [PTR_BITS-1:0] stop_idx, ctop_idx;
  logic [CNT_BITS-1:0] scnt_q, scnt_d, ccnt_q, ccnt_d;

  assign stop_idx  = sptr_q - 1'b1;
  assign ctop_idx  = cptr_q - 1'b1;
  assign top       = spec_q[stop_idx];
  assign top_valid = scnt_q != '0;

  // committed copy next state from EXE-resolved calls/returns
  always_comb begin
    com_d  = com_q;
    cptr_d = cptr_q;
    ccnt_d = ccnt_q;
    if (commit_push && commit_pop && ccnt_q != '0) begin
      com_d[ctop_idx] = commit_push_addr;
    end else if (commit_push) begin
      com_d[cptr_q] = commit_push_addr;
      cptr_d        = cptr_q + 1'b1;
      ccnt_d        = (ccnt_q == CNT_BITS'(DEPTH)) ? ccnt_q : ccnt_q + 1'b1;
    end else if (commit_pop && ccnt_q != '0) begin
      cptr_d = cptr_q - 1'b1;
      ccnt_d = ccnt_q - 1'b1;
    end
  end

  // speculative copy next state; flush forwards the committed next state
  always_comb begin
    spec_d = spec_q;
    sptr_d = sptr_q;
    scnt_d = scnt_q;
    if (flush) begin
      spec_d = com_d;
      sptr_d = cptr_d;
      scnt_d = ccnt_d;
    end else if (spec_push && spec_pop && scnt_q != '0) begin
      spec_d[stop_idx] = spec_push_addr;
    end else if (spec_push) begin
      spec_d[sptr_q] = spec_push_addr;
      sptr_d         = sptr_q + 1'b1;
      scnt_d         = (scnt_q == CNT_BITS'(DEPTH)) ? scnt_q : scnt_q + 1'b1;
    end else if (spec_pop && scnt_q != '0) begin
      sptr_d = sptr_q - 1'b1;
      scnt_d = scnt_q - 1'b1;
    end
  end

  // state registers, asynchronously cleared
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        spec_q[i] <= '0;
        com_q[i]  <= '0;
      end
      sptr_q <= '0;
      cptr_q <= '0;
      scnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      spec_q <= spec_d;
      com_q  <= com_d;
      sptr_q <= sptr_d;
      cptr_q <= cptr_d;
      scnt_q <= scnt_d;
      ccnt_q <= ccnt_d;
    end
  end
endmodule
